// File: rtl/alu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the lab ALU datapath.
// Owns the PC, resolves beq/bsq from ALU flags, stalls in MEM until MEM_READY.
module alu_sequencer #(
   parameter int PC_W    = 8,
   parameter int ALU_LAT = 1
) (
   input  logic            clk_i,
   input  logic            reset_n_i,
   input  logic            start_i,
   input  logic [15:0]     instr_i,
   input  logic            zero_i,
   input  logic            equal_i,
   input  logic            mem_ready_i,
   output logic [PC_W-1:0] pc_o,
   output logic [3:0]      alu_op_o,
   output logic [3:0]      rf_ra_o,
   output logic [3:0]      rf_rb_o,
   output logic [3:0]      rf_wa_o,
   output logic            rf_we_o,
   output logic            rf_wsel_o,
   output logic            mem_we_o,
   output logic            mem_re_o,
   output logic            busy_o,
   output logic            halted_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
   } state_t;

   localparam logic [1:0] EXEC_LAST = 2'(ALU_LAT - 1);

   state_t          state_q;
   logic [PC_W-1:0] pc_q;
   logic [15:0]     ir_q;
   logic [1:0]      exec_cnt_q;
   logic [3:0]      alu_op_q;
   logic [3:0]      rf_wa_q;
   logic            rf_we_q;
   logic            rf_wsel_q;
   logic            mem_we_q;
   logic            mem_re_q;
   logic            busy_q;
   logic            halted_q;

   logic [3:0]      dec_op;
   logic [3:0]      ir_op;
   logic [PC_W-1:0] pc_inc_d;
   logic [PC_W-1:0] pc_br_d;
   logic            take_d;
   logic            ir_is_alu;

   assign dec_op    = instr_i[15:12];
   assign ir_op     = ir_q[15:12];
   assign pc_inc_d  = pc_q + PC_W'(1);
   // imm4 is signed; PC_W must be wider than 4 for the sign extension.
   assign pc_br_d   = pc_inc_d + {{(PC_W-4){ir_q[3]}}, ir_q[3:0]};
   assign take_d    = ((ir_op == 4'd5) && equal_i) || ((ir_op == 4'd10) && zero_i);
   assign ir_is_alu = (ir_op == 4'd2) || (ir_op == 4'd3) || (ir_op == 4'd4) ||
                      (ir_op == 4'd8) || (ir_op == 4'd9);

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         ir_q       <= '0;
         exec_cnt_q <= '0;
         alu_op_q   <= '0;
         rf_wa_q    <= '0;
         rf_we_q    <= 1'b0;
         rf_wsel_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_re_q   <= 1'b0;
         busy_q     <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         rf_we_q <= 1'b0;
         case (state_q)
            S_IDLE, S_HALTED: begin
               if (start_i) begin
                  state_q  <= S_FETCH;
                  pc_q     <= '0;
                  busy_q   <= 1'b1;
                  halted_q <= 1'b0;
               end
            end
            S_FETCH: state_q <= S_DECODE;
            S_DECODE: begin
               // Read addresses come straight out of IR, so they hold until the next DECODE.
               ir_q <= instr_i;
               if (dec_op == 4'd1) begin
                  state_q  <= S_HALTED;
                  busy_q   <= 1'b0;
                  halted_q <= 1'b1;
               end else if ((dec_op == 4'd0) || (dec_op >= 4'd11)) begin
                  state_q <= S_FETCH;
                  pc_q    <= pc_inc_d;
               end else begin
                  state_q    <= S_EXEC;
                  alu_op_q   <= dec_op;
                  exec_cnt_q <= '0;
               end
            end
            S_EXEC: begin
               if (exec_cnt_q != EXEC_LAST) begin
                  exec_cnt_q <= exec_cnt_q + 2'd1;
               end else if ((ir_op == 4'd6) || (ir_op == 4'd7)) begin
                  state_q  <= S_MEM;
                  mem_we_q <= (ir_op == 4'd6);
                  mem_re_q <= (ir_op == 4'd7);
               end else if (ir_is_alu) begin
                  state_q   <= S_WB;
                  rf_we_q   <= 1'b1;
                  rf_wa_q   <= ir_q[11:8];
                  rf_wsel_q <= 1'b0;
               end else begin
                  state_q  <= S_FETCH;
                  alu_op_q <= '0;
                  pc_q     <= take_d ? pc_br_d : pc_inc_d;
               end
            end
            S_MEM: begin
               if (mem_ready_i) begin
                  mem_we_q <= 1'b0;
                  mem_re_q <= 1'b0;
                  if (ir_op == 4'd7) begin
                     state_q   <= S_WB;
                     rf_we_q   <= 1'b1;
                     rf_wa_q   <= ir_q[11:8];
                     rf_wsel_q <= 1'b1;
                  end else begin
                     state_q  <= S_FETCH;
                     alu_op_q <= '0;
                     pc_q     <= pc_inc_d;
                  end
               end
            end
            S_WB: begin
               state_q  <= S_FETCH;
               alu_op_q <= '0;
               pc_q     <= pc_inc_d;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign pc_o      = pc_q;
   assign alu_op_o  = alu_op_q;
   assign rf_ra_o   = ir_q[7:4];
   assign rf_rb_o   = ir_q[3:0];
   assign rf_wa_o   = rf_wa_q;
   assign rf_we_o   = rf_we_q;
   assign rf_wsel_o = rf_wsel_q;
   assign mem_we_o  = mem_we_q;
   assign mem_re_o  = mem_re_q;
   assign busy_o    = busy_q;
   assign halted_o  = halted_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a synchronous instruction memory model.
module tb_alu_sequencer;
   localparam int L = 2;

   logic        clk = 1'b0;
   logic        reset_n_i = 1'b0;
   logic        start_i = 1'b0;
   logic [15:0] instr_i;
   logic        zero_i = 1'b0;
   logic        equal_i = 1'b0;
   logic        mem_ready_i = 1'b0;
   logic [7:0]  pc_o;
   logic [3:0]  alu_op_o, rf_ra_o, rf_rb_o, rf_wa_o;
   logic        rf_we_o, rf_wsel_o, mem_we_o, mem_re_o, busy_o, halted_o;

   logic [15:0] imem [0:255];
   int          we_cnt = 0;
   logic        we_clr = 1'b0;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   alu_sequencer #(.PC_W(8), .ALU_LAT(L)) dut (
      .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i), .instr_i(instr_i),
      .zero_i(zero_i), .equal_i(equal_i), .mem_ready_i(mem_ready_i),
      .pc_o(pc_o), .alu_op_o(alu_op_o), .rf_ra_o(rf_ra_o), .rf_rb_o(rf_rb_o),
      .rf_wa_o(rf_wa_o), .rf_we_o(rf_we_o), .rf_wsel_o(rf_wsel_o),
      .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .busy_o(busy_o), .halted_o(halted_o)
   );

   always @(posedge clk) instr_i <= imem[pc_o];

   always @(posedge clk) begin
      if (we_clr) we_cnt <= 0;
      else if (rf_we_o) we_cnt <= we_cnt + 1;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_mem;
      for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
   endtask

   // Leaves the bench at the negedge of the first FETCH cycle (PC 0).
   task automatic start_prog;
      reset_n_i = 1'b0; we_clr = 1'b1; start_i = 1'b0;
      step(1);
      reset_n_i = 1'b1; we_clr = 1'b0; start_i = 1'b1;
      step(1);
      start_i = 1'b0;
   endtask

   task automatic test_reset;
      logic [29:0] outs;
      reset_n_i = 1'b0; start_i = 1'b0; we_clr = 1'b1;
      step(2);
      we_clr = 1'b0;
      outs = {pc_o, alu_op_o, rf_ra_o, rf_rb_o, rf_wa_o, rf_we_o, rf_wsel_o,
              mem_we_o, mem_re_o, busy_o, halted_o};
      n_cmp++; if (outs !== 30'h0) begin n_err++; $display("FAIL reset_outs: got %h want 0", outs); end
      reset_n_i = 1'b1;
      step(3);
      n_cmp++; if ({busy_o, pc_o} !== 9'h0) begin n_err++; $display("FAIL idle_hold: got busy=%b pc=%h want 0/0", busy_o, pc_o); end
   endtask

   task automatic test_alu_seq;
      clear_mem();
      imem[0] = 16'h2123; imem[1] = 16'h9F45; imem[2] = 16'hB000; imem[3] = 16'h1000;
      start_prog();
      n_cmp++; if ({busy_o, pc_o, alu_op_o} !== {1'b1, 8'h00, 4'h0}) begin n_err++; $display("FAIL fetch0: got busy=%b pc=%h op=%h", busy_o, pc_o, alu_op_o); end
      step(1);
      n_cmp++; if ({alu_op_o, rf_we_o} !== 5'h00) begin n_err++; $display("FAIL decode0: got op=%h we=%b want 0/0", alu_op_o, rf_we_o); end
      step(1);
      n_cmp++; if ({rf_ra_o, rf_rb_o, alu_op_o} !== 12'h232) begin n_err++; $display("FAIL exec0: got ra=%h rb=%h op=%h want 2/3/2", rf_ra_o, rf_rb_o, alu_op_o); end
      step(L - 1);
      n_cmp++; if ({alu_op_o, rf_we_o, pc_o} !== {4'h2, 1'b0, 8'h00}) begin n_err++; $display("FAIL exec0_last: got op=%h we=%b pc=%h", alu_op_o, rf_we_o, pc_o); end
      step(1);
      n_cmp++; if ({rf_we_o, rf_wa_o, rf_wsel_o, alu_op_o, pc_o} !== {1'b1, 4'h1, 1'b0, 4'h2, 8'h00}) begin n_err++; $display("FAIL wb0: got we=%b wa=%h wsel=%b op=%h pc=%h", rf_we_o, rf_wa_o, rf_wsel_o, alu_op_o, pc_o); end
      step(1);
      n_cmp++; if ({pc_o, rf_we_o, alu_op_o} !== {8'h01, 1'b0, 4'h0}) begin n_err++; $display("FAIL after_wb0: got pc=%h we=%b op=%h want 01/0/0", pc_o, rf_we_o, alu_op_o); end
      step(1 + L);
      step(1);
      n_cmp++; if ({rf_we_o, rf_wa_o, rf_ra_o, rf_rb_o, alu_op_o, rf_wsel_o} !== {1'b1, 4'hF, 4'h4, 4'h5, 4'h9, 1'b0}) begin n_err++; $display("FAIL wb1: got we=%b wa=%h ra=%h rb=%h op=%h wsel=%b", rf_we_o, rf_wa_o, rf_ra_o, rf_rb_o, alu_op_o, rf_wsel_o); end
      step(1);
      n_cmp++; if (pc_o !== 8'h02) begin n_err++; $display("FAIL after_wb1: got pc=%h want 02", pc_o); end
      step(2);
      n_cmp++; if ({pc_o, we_cnt[3:0]} !== {8'h03, 4'd2}) begin n_err++; $display("FAIL nop11: got pc=%h we_cnt=%0d want 03/2", pc_o, we_cnt); end
      step(2);
      n_cmp++; if ({halted_o, busy_o, pc_o} !== {1'b1, 1'b0, 8'h03}) begin n_err++; $display("FAIL halt_after_seq: got h=%b b=%b pc=%h", halted_o, busy_o, pc_o); end
   endtask

   task automatic test_branch(input logic [15:0] ins, input logic eq, input logic zr, input logic [7:0] exp_pc);
      clear_mem();
      imem[4] = ins; equal_i = eq; zero_i = zr;
      start_prog();
      step(2);
      start_i = 1'b1;
      step(1);
      start_i = 1'b0;
      n_cmp++; if (pc_o !== 8'h01) begin n_err++; $display("FAIL br_start_ignored %h: got pc=%h want 01", ins, pc_o); end
      step(6 + L);
      n_cmp++; if ({pc_o, alu_op_o} !== {8'h04, ins[15:12]}) begin n_err++; $display("FAIL br_exec %h: got pc=%h op=%h want 04/%h", ins, pc_o, alu_op_o, ins[15:12]); end
      step(1);
      n_cmp++; if ({pc_o, alu_op_o, busy_o} !== {exp_pc, 4'h0, 1'b1}) begin n_err++; $display("FAIL br_target %h eq=%b z=%b: got pc=%h op=%h busy=%b want pc=%h", ins, eq, zr, pc_o, alu_op_o, busy_o, exp_pc); end
      n_cmp++; if (we_cnt !== 0) begin n_err++; $display("FAIL br_no_we %h: got we_cnt=%0d want 0", ins, we_cnt); end
      equal_i = 1'b0; zero_i = 1'b0;
   endtask

   task automatic test_mem_read;
      clear_mem();
      imem[0] = 16'h7400; imem[1] = 16'h1000;
      start_prog();
      mem_ready_i = 1'b1;
      step(1 + L);
      mem_ready_i = 1'b0;
      n_cmp++; if (mem_re_o !== 1'b0) begin n_err++; $display("FAIL rd_pre_mem: got re=%b want 0", mem_re_o); end
      step(1);
      n_cmp++; if ({mem_re_o, mem_we_o, alu_op_o} !== {1'b1, 1'b0, 4'h7}) begin n_err++; $display("FAIL rd_mem_entry: got re=%b we=%b op=%h", mem_re_o, mem_we_o, alu_op_o); end
      step(2);
      n_cmp++; if ({mem_re_o, rf_we_o} !== 2'b10) begin n_err++; $display("FAIL rd_stall: got re=%b rf_we=%b want 1/0", mem_re_o, rf_we_o); end
      step(1);
      n_cmp++; if (mem_re_o !== 1'b1) begin n_err++; $display("FAIL rd_stall_last: got re=%b want 1", mem_re_o); end
      mem_ready_i = 1'b1;
      step(1);
      mem_ready_i = 1'b0;
      n_cmp++; if ({mem_re_o, rf_we_o, rf_wsel_o, rf_wa_o, alu_op_o} !== {1'b0, 1'b1, 1'b1, 4'h4, 4'h7}) begin n_err++; $display("FAIL rd_wb: got re=%b we=%b wsel=%b wa=%h op=%h", mem_re_o, rf_we_o, rf_wsel_o, rf_wa_o, alu_op_o); end
      step(1);
      n_cmp++; if ({pc_o, rf_we_o} !== {8'h01, 1'b0}) begin n_err++; $display("FAIL rd_after_wb: got pc=%h we=%b want 01/0", pc_o, rf_we_o); end
      step(2);
      n_cmp++; if ({halted_o, we_cnt[3:0]} !== {1'b1, 4'd1}) begin n_err++; $display("FAIL rd_end: got halted=%b we_cnt=%0d want 1/1", halted_o, we_cnt); end
   endtask

   task automatic test_mem_write;
      clear_mem();
      imem[0] = 16'h6000; imem[1] = 16'h1000;
      mem_ready_i = 1'b0;
      start_prog();
      step(2 + L);
      n_cmp++; if ({mem_we_o, mem_re_o, alu_op_o} !== {1'b1, 1'b0, 4'h6}) begin n_err++; $display("FAIL wr_mem_entry: got we=%b re=%b op=%h", mem_we_o, mem_re_o, alu_op_o); end
      step(3);
      n_cmp++; if ({mem_we_o, pc_o} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL wr_stall: got we=%b pc=%h want 1/00", mem_we_o, pc_o); end
      mem_ready_i = 1'b1;
      step(1);
      mem_ready_i = 1'b0;
      n_cmp++; if ({mem_we_o, pc_o, alu_op_o} !== {1'b0, 8'h01, 4'h0}) begin n_err++; $display("FAIL wr_done: got we=%b pc=%h op=%h want 0/01/0", mem_we_o, pc_o, alu_op_o); end
      step(2);
      n_cmp++; if ({halted_o, we_cnt[3:0]} !== {1'b1, 4'd0}) begin n_err++; $display("FAIL wr_end: got halted=%b we_cnt=%0d want 1/0", halted_o, we_cnt); end
   endtask

   task automatic test_mem_fast;
      clear_mem();
      imem[0] = 16'h6000; imem[1] = 16'h1000;
      mem_ready_i = 1'b1;
      start_prog();
      step(2 + L);
      n_cmp++; if (mem_we_o !== 1'b1) begin n_err++; $display("FAIL fast_entry: got we=%b want 1", mem_we_o); end
      step(1);
      n_cmp++; if ({mem_we_o, pc_o} !== {1'b0, 8'h01}) begin n_err++; $display("FAIL fast_done: got we=%b pc=%h want 0/01", mem_we_o, pc_o); end
      mem_ready_i = 1'b0;
   endtask

   task automatic test_halt;
      int bad;
      clear_mem();
      imem[0] = 16'h0000; imem[1] = 16'h1000;
      start_prog();
      step(4);
      n_cmp++; if ({halted_o, busy_o, pc_o} !== {1'b1, 1'b0, 8'h01}) begin n_err++; $display("FAIL halt_entry: got h=%b b=%b pc=%h want 1/0/01", halted_o, busy_o, pc_o); end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (pc_o !== 8'h01 || halted_o !== 1'b1 || busy_o !== 1'b0) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL halt_frozen: got %0d bad cycles want 0", bad); end
      start_i = 1'b1;
      step(1);
      start_i = 1'b0;
      n_cmp++; if ({pc_o, busy_o, halted_o} !== {8'h00, 1'b1, 1'b0}) begin n_err++; $display("FAIL restart: got pc=%h b=%b h=%b want 00/1/0", pc_o, busy_o, halted_o); end
   endtask

   task automatic test_wrap;
      clear_mem();
      start_prog();
      step(510);
      n_cmp++; if (pc_o !== 8'hFF) begin n_err++; $display("FAIL wrap_ff: got pc=%h want ff", pc_o); end
      step(2);
      n_cmp++; if ({pc_o, busy_o} !== {8'h00, 1'b1}) begin n_err++; $display("FAIL wrap_0: got pc=%h busy=%b want 00/1", pc_o, busy_o); end
   endtask

   task automatic test_reset_abort;
      logic [29:0] outs;
      clear_mem();
      imem[0] = 16'h6AB5;
      mem_ready_i = 1'b0;
      start_prog();
      step(3 + L);
      n_cmp++; if ({mem_we_o, rf_ra_o, rf_rb_o, alu_op_o} !== {1'b1, 4'hB, 4'h5, 4'h6}) begin n_err++; $display("FAIL abort_pre: got we=%b ra=%h rb=%h op=%h", mem_we_o, rf_ra_o, rf_rb_o, alu_op_o); end
      reset_n_i = 1'b0;
      step(1);
      outs = {pc_o, alu_op_o, rf_ra_o, rf_rb_o, rf_wa_o, rf_we_o, rf_wsel_o,
              mem_we_o, mem_re_o, busy_o, halted_o};
      n_cmp++; if (outs !== 30'h0) begin n_err++; $display("FAIL abort_outs: got %h want 0", outs); end
      reset_n_i = 1'b1;
      step(2);
      n_cmp++; if ({busy_o, mem_we_o, we_cnt[3:0]} !== 6'h0) begin n_err++; $display("FAIL abort_idle: got busy=%b we=%b we_cnt=%0d", busy_o, mem_we_o, we_cnt); end
   endtask

   initial begin
      clear_mem();
      test_reset();
      test_alu_seq();
      test_branch(16'h501E, 1'b1, 1'b0, 8'h03);
      test_branch(16'h501E, 1'b0, 1'b0, 8'h05);
      test_branch(16'hA003, 1'b0, 1'b1, 8'h08);
      test_branch(16'hA003, 1'b1, 1'b0, 8'h05);
      test_mem_read();
      test_mem_write();
      test_mem_fast();
      test_halt();
      test_wrap();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
